// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
// Master drives the address/data phase signals, slave answers.
interface ahb_lite_sram_slave_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
);
  logic                 HSEL;
  logic [ADDRWIDTH-1:0] HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [DATAWIDTH-1:0] HWDATA;
  logic                 HREADY;
  logic                 HREADYOUT;
  logic                 HRESP;
  logic [DATAWIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: pipelined word memory with programmable
// wait states and the two-cycle ERROR response.
module ahb_lite_sram_slave #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = '0
) (
  input logic HCLK,
  input logic HRESET,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int BPW  = DATAWIDTH / 8;
  localparam int BW   = $clog2(BPW);
  localparam int DW   = $clog2(DEPTH);
  localparam int OFFW = BW + DW;
  localparam logic [2:0] WLOAD =
    3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, WAIT, ERR1, ERR2
  } state_t;

  state_t state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          dv_q;
  logic          dwr_q;
  logic [2:0]    dsz_q;
  logic [BW-1:0] dlo_q;
  logic [DW-1:0] didx_q;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic           rdy;
  logic           cap;
  logic           take;
  logic           hit;
  logic           big;
  logic           mis;
  logic           err;
  logic           done;
  logic [BW-1:0]  lo;
  logic [BPW-1:0] be;
  logic           unused_ok;

  assign unused_ok = ^bus.HBURST;

  assign rdy  = (state_q == IDLE) || (state_q == ERR2);
  assign cap  = bus.HSEL && bus.HREADY &&
                (bus.HTRANS == 2'b10 ||
                 bus.HTRANS == 2'b11);
  assign take = cap && rdy;

  assign lo  = bus.HADDR[BW-1:0];
  assign hit = bus.HADDR[ADDRWIDTH-1:OFFW] ==
               BASE_ADDR[ADDRWIDTH-1:OFFW];
  assign big = bus.HSIZE > 3'(BW);

  always_comb begin
    mis = 1'b0;
    for (int i = 0; i < BW; i++)
      if (3'(i) < bus.HSIZE)
        mis = mis | lo[i];
  end

  assign err = !hit || big || mis;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, ERR2: begin
        state_d = IDLE;
        if (take) begin
          if (err) begin
            state_d = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WLOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 3'd1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      dwr_q   <= 1'b0;
      dsz_q   <= '0;
      dlo_q   <= '0;
      didx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rdy)
        dv_q <= take && !err;
      if (take) begin
        dwr_q  <= bus.HWRITE;
        dsz_q  <= bus.HSIZE;
        dlo_q  <= lo;
        didx_q <= bus.HADDR[OFFW-1:BW];
      end
    end
  end

  // an OKAY data phase completes in the first IDLE cycle after capture
  assign done = (state_q == IDLE) && dv_q;

  always_comb begin
    be = '0;
    for (int b = 0; b < BPW; b++)
      be[b] = (BW'(b) >> dsz_q) == (dlo_q >> dsz_q);
  end

  always_ff @(posedge HCLK) begin
    if (done && dwr_q && !HRESET)
      for (int b = 0; b < BPW; b++)
        if (be[b])
          mem[didx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
  end

  assign bus.HRDATA    = (done && !dwr_q) ? mem[didx_q] : '0;
  assign bus.HREADYOUT = rdy;
  assign bus.HRESP     = (state_q == ERR1) ||
                         (state_q == ERR2);

endmodule

// File: doc/ahb_lite_sram_slave.md
AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, meaning HWDATA/HRDATA width in bits (32 or 64).
REQ-002 SHALL have parameter ADDRWIDTH, default 32, meaning HADDR width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning memory size in DATAWIDTH words (power of 2).
REQ-004 SHALL have parameter WAIT_STATES, default 1, meaning inserted wait cycles per OKAY transfer (0..7).
REQ-005 SHALL have parameter BASE_ADDR, default 0, meaning byte base address (aligned to DEPTH*DATAWIDTH/8).
REQ-006 SHALL have port HCLK  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port HRESET  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports HSEL  in  1  slave select; HADDR  in  ADDRWIDTH  byte address; HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
REQ-009 SHALL have ports HWRITE  in  1  write=1; HSIZE  in  3  transfer size; HBURST  in  3  accepted, unused.
REQ-010 SHALL have ports HWDATA  in  DATAWIDTH  write data; HREADY  in  1  bus-level ready.
REQ-011 SHALL have ports HREADYOUT  out  1  slave ready; HRESP  out  1  0=OKAY 1=ERROR; HRDATA  out  DATAWIDTH  read data.

Function
REQ-012 SHALL capture an address phase only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; it SHALL register HADDR, HWRITE and HSIZE.
REQ-013 SHALL treat IDLE, BUSY, HSEL=0 or HREADY=0 as no transfer: the next cycle gives HREADYOUT=1, HRESP=0.
REQ-014 SHALL classify a captured transfer as an error when the address is outside BASE_ADDR..BASE_ADDR+DEPTH*DATAWIDTH/8-1, HSIZE exceeds DATAWIDTH, or HADDR is not aligned to HSIZE.
REQ-015 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2.
REQ-016 FSM: an OKAY capture goes to WAIT if WAIT_STATES>0, else stays IDLE (zero-wait data phase); an error capture goes to ERR1.
REQ-017 WAIT: HREADYOUT=0; a counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 it returns to IDLE, where the data phase completes with HREADYOUT=1.
REQ-018 ERR1: HREADYOUT=0, HRESP=1; always goes to ERR2. ERR2: HREADYOUT=1, HRESP=1; goes to IDLE, or to WAIT/ERR1 if a new transfer is captured in the same cycle.
REQ-019 Data-phase completion cycle SHALL overlap with the next address phase, giving full pipelining; back-to-back transfers SHALL sustain one transfer per WAIT_STATES+1 cycles.
REQ-020 Writes SHALL take HWDATA in the completion cycle and update memory at the closing edge, enabling only the byte lanes selected by HSIZE and HADDR low bits (little-endian).
REQ-021 Reads SHALL drive HRDATA with the full addressed word during the completion cycle; HRDATA SHALL be 0 in every other cycle.
REQ-022 A write followed back-to-back by a read of the same address SHALL return the newly written data.
REQ-023 Errored transfers SHALL NOT modify memory; the word index SHALL be HADDR[log2(DATAWIDTH/8)+log2(DEPTH)-1:log2(DATAWIDTH/8)].

Reset
REQ-024 While HRESET=1 at a rising edge, the FSM SHALL enter IDLE, the counter SHALL clear and registered address-phase state SHALL clear; HREADYOUT=1, HRESP=0, HRDATA=0 next cycle.
REQ-025 Reset asserted mid-transfer (WAIT/ERR1) SHALL abandon that transfer with no memory write; memory contents SHALL NOT be reset.

Verification
REQ-026 WAIT_STATES=1: NONSEQ word write 0xDEADBEEF to 0x10, then a read of 0x10 -> HREADYOUT low 1 cycle per transfer, read returns 0xDEADBEEF, HRESP=0.
REQ-027 Byte write 0xAA to 0x13 over word 0x11223344 -> subsequent word read of 0x10 returns 0xAA223344.
REQ-028 Read of BASE_ADDR+0x400 (DEPTH=256, 32-bit) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
REQ-029 WAIT_STATES=0: four back-to-back SEQ writes 0x0..0xC, then four reads -> HREADYOUT stays 1 throughout, data matches.
REQ-030 HRESET pulsed during WAIT of a write to 0x20 -> outputs return to reset values next cycle; later read of 0x20 returns its prior value.
REQ-031 HTRANS=BUSY, or HSEL=0 with HTRANS=NONSEQ -> no capture, HREADYOUT=1, HRESP=0, HRDATA=0.
